// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester identifiers and the read-latency limits.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  // Arbiter FSM states. Encoding is fixed so debug tools can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Requester identifiers. These also index the round-robin pointer.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Largest supported memory read latency and the counter width that holds it.
  localparam int RD_LAT_MAX = 3;
  localparam int LAT_CNT_W  = 2;

  // Port that gets priority after the given port has been served.
  function automatic req_id_t other_port(input req_id_t id);
    return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//
// Ports:
//   valid0, valid1 : request present on port 0 / port 1
//   rr_ptr         : port that wins when both are requesting
//   gnt0, gnt1     : one-hot grant, or all zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = valid0 && (!valid1 || (rr_ptr == REQ_CPU));
    gnt1 = valid1 && (!valid0 || (rr_ptr == REQ_DMA));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the CPU load/store port (req0)
// and the loader/DMA port (req1). One transaction is in flight at a time and
// grants alternate round-robin when both ports request together.
//
// Parameters:
//   ADDR_W : word address width (requester and memory side)
//   DATA_W : data width
//   RD_LAT : memory read latency in cycles after the mem_re cycle, 0..3
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata : request from port N (N = 0 CPU, 1 DMA)
//   reqN_ready               : request accepted this cycle (valid && ready)
//   reqN_rvalid              : one-cycle pulse, read data valid on port N
//   reqN_rdata               : read data, held until the next rvalid on N
//   mem_addr, mem_wdata      : registered address / write data to memory
//   mem_we, mem_re           : one-cycle write / read strobes
//   mem_rdata                : memory read data, RD_LAT cycles after mem_re
//   busy                     : a transaction is in progress (not IDLE)
//
// Timeline for a request accepted in cycle T:
//   T            : reqN_ready high (combinational, IDLE only)
//   T+1          : strobe on the memory port (ISSUE)
//   T+1+RD_LAT   : mem_rdata captured for reads
//   T+2+RD_LAT   : reqN_rvalid pulse, arbiter already back in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  state_t                 state;
  req_id_t                rr_ptr;
  req_id_t                owner;
  logic                   is_write;
  logic [LAT_CNT_W-1:0]   lat_cnt;

  logic                   gnt0;
  logic                   gnt1;
  logic                   accept;
  req_id_t                sel;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   capture;

  rr_arb2 u_rr_arb2 (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .rr_ptr (rr_ptr),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Ready is only offered in IDLE, and never while reset is asserted so that
  // nothing looks accepted in a cycle whose state update is being discarded.
  always_comb begin
    req0_ready = (state == IDLE) && !rst && gnt0;
    req1_ready = (state == IDLE) && !rst && gnt1;
    accept     = req0_ready || req1_ready;
    sel        = req1_ready ? REQ_DMA : REQ_CPU;
    sel_we     = req1_ready ? req1_we    : req0_we;
    sel_addr   = req1_ready ? req1_addr  : req0_addr;
    sel_wdata  = req1_ready ? req1_wdata : req0_wdata;
  end

  // Read data is sampled in ISSUE when the memory is combinational, otherwise
  // in the last WAIT cycle (lat_cnt == 1), which is RD_LAT cycles after mem_re.
  always_comb begin
    capture = 1'b0;
    if (!is_write) begin
      if (state == ISSUE && RD_LAT == 0)
        capture = 1'b1;
      else if (state == WAIT && lat_cnt == LAT_CNT_W'(1))
        capture = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= REQ_CPU;
      owner       <= REQ_CPU;
      is_write    <= 1'b0;
      lat_cnt     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      // Strobes and response pulses are single-cycle unless set below.
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;

      // Response stage: route the captured word to the owning port.
      if (capture) begin
        if (owner == REQ_CPU) begin
          req0_rdata  <= mem_rdata;
          req0_rvalid <= 1'b1;
        end else begin
          req1_rdata  <= mem_rdata;
          req1_rvalid <= 1'b1;
        end
      end

      unique case (state)
        // Accept stage: latch the winning request and hand priority over.
        IDLE: begin
          if (accept) begin
            owner     <= sel;
            is_write  <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            mem_re    <= !sel_we;
            rr_ptr    <= other_port(sel);
            state     <= ISSUE;
          end
        end

        // Issue stage: the strobe is on the memory port this cycle.
        ISSUE: begin
          if (is_write || RD_LAT == 0) begin
            state <= IDLE;
          end else begin
            lat_cnt <= LAT_CNT_W'(RD_LAT);
            state   <= WAIT;
          end
        end

        // Wait stage: count down the memory read latency.
        WAIT: begin
          lat_cnt <= lat_cnt - LAT_CNT_W'(1);
          if (lat_cnt == LAT_CNT_W'(1))
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk;
  logic rst;

  // Four DUTs, instance k has RD_LAT = k. Index [k][p]: p = requester port.
  logic        vv   [4][2];
  logic        vwe  [4][2];
  logic [15:0] va   [4][2];
  logic [15:0] vd   [4][2];
  logic        rdy  [4][2];
  logic        rv   [4][2];
  logic [15:0] rd   [4][2];
  logic [15:0] maddr[4];
  logic [15:0] mwd  [4];
  logic        mwe  [4];
  logic        mre  [4];
  logic [15:0] mrd  [4];
  logic        busy [4];

  // Memory models, one per DUT.
  logic [15:0] mem [4][256];
  logic [2:0]  pv  [4];
  logic [15:0] pd  [4][3];

  // Transaction-level reference model state.
  int          mcyc;
  int          free_at [4];
  int          s_cyc   [4];
  int          rv_cyc  [4];
  logic        last    [4];
  logic        s_we    [4];
  logic        rv_port [4];
  logic [15:0] rv_data [4];
  logic [15:0] e_maddr [4];
  logic [15:0] e_mwd   [4];
  logic [15:0] held    [4][2];
  logic [15:0] shadow  [4][256];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(g)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(vv[g][0]), .req0_we(vwe[g][0]), .req0_addr(va[g][0]), .req0_wdata(vd[g][0]),
      .req0_ready(rdy[g][0]), .req0_rvalid(rv[g][0]), .req0_rdata(rd[g][0]),
      .req1_valid(vv[g][1]), .req1_we(vwe[g][1]), .req1_addr(va[g][1]), .req1_wdata(vd[g][1]),
      .req1_ready(rdy[g][1]), .req1_rvalid(rv[g][1]), .req1_rdata(rd[g][1]),
      .mem_addr(maddr[g]), .mem_wdata(mwd[g]), .mem_we(mwe[g]), .mem_re(mre[g]),
      .mem_rdata(mrd[g]), .busy(busy[g])
    );
    // Read data is only meaningful exactly RD_LAT cycles after mem_re.
    if (g == 0) begin : g_l0
      assign mrd[g] = mre[g] ? mem[g][maddr[g][7:0]] : (maddr[g] ^ 16'hDEAD);
    end else begin : g_ln
      assign mrd[g] = pv[g][g-1] ? pd[g][g-1] : (maddr[g] ^ 16'hDEAD);
    end
  end

  function automatic logic [15:0] mem_init(int a);
    return 16'((a * 499) ^ 16'hC35A);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= mem_init(a);
      end else if (mwe[k]) begin
        mem[k][maddr[k][7:0]] <= mwd[k];
      end
      pv[k]    <= {pv[k][1:0], mre[k]};
      pd[k][0] <= mem[k][maddr[k][7:0]];
      pd[k][1] <= pd[k][0];
      pd[k][2] <= pd[k][1];
    end
  end

  // Arbitration rule: a request is taken only when the memory is free; with
  // both ports asking, the one not served last wins.
  function automatic logic exp_rdy(int k, int p);
    logic free;
    free = !rst && (mcyc >= free_at[k]);
    if (p == 0) return free && vv[k][0] && (!vv[k][1] || last[k]);
    return free && vv[k][1] && (!vv[k][0] || !last[k]);
  endfunction

  function automatic logic [6:0] ctl(int k);
    return {rdy[k][0], rdy[k][1], mwe[k], mre[k], rv[k][0], rv[k][1], busy[k]};
  endfunction

  task automatic step_model();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        free_at[k] = 0; last[k] = 1'b1; s_cyc[k] = -1; rv_cyc[k] = -1;
        s_we[k] = 1'b0; rv_port[k] = 1'b0; rv_data[k] = '0;
        held[k][0] = '0; held[k][1] = '0; e_maddr[k] = '0; e_mwd[k] = '0;
        for (int a = 0; a < 256; a++) shadow[k][a] = mem_init(a);
      end else if (exp_rdy(k, 0) || exp_rdy(k, 1)) begin
        int p;
        p = exp_rdy(k, 1) ? 1 : 0;
        s_cyc[k]   = mcyc + 1;
        s_we[k]    = vwe[k][p];
        e_maddr[k] = va[k][p];
        e_mwd[k]   = vd[k][p];
        last[k]    = (p == 1);
        if (vwe[k][p]) begin
          shadow[k][va[k][p][7:0]] = vd[k][p];
          free_at[k] = mcyc + 2;
        end else begin
          rv_cyc[k]  = mcyc + 2 + k;
          rv_port[k] = (p == 1);
          rv_data[k] = shadow[k][va[k][p][7:0]];
          free_at[k] = mcyc + 2 + k;
        end
      end
    end
    mcyc++;
    for (int k = 0; k < 4; k++)
      if (mcyc == rv_cyc[k]) held[k][rv_port[k]] = rv_data[k];
  endtask

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        vv[k][p] = 1'b0; vwe[k][p] = 1'b0; va[k][p] = '0; vd[k][p] = '0;
      end
  endtask

  task automatic drive(int k, int p, logic we, logic [15:0] a, logic [15:0] d);
    vv[k][p] = 1'b1; vwe[k][p] = we; va[k][p] = a; vd[k][p] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if ({ctl(k), rd[k][0], rd[k][1], maddr[k], mwd[k]} !== 71'd0) begin
          n_bad++;
          $display("FAIL reset_idle dut%0d cyc%0d: ctl=%b rd0=%h rd1=%h addr=%h wd=%h, want all 0",
                   k, c, ctl(k), rd[k][0], rd[k][1], maddr[k], mwd[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    logic [6:0] exp_c [6];
    exp_c = '{7'b1000000, 7'b0010001, 7'b1000000, 7'b0001001, 7'b0000100, 7'b0000000};
    drive(0, 0, 1'b1, 16'h0010, 16'hBEEF);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl(0) !== exp_c[c]) begin
        n_bad++;
        $display("FAIL wr_rd_ctl T+%0d: got %b want %b", c, ctl(0), exp_c[c]);
      end
      if (c == 1 || c == 3) begin
        n_cmp++;
        if (maddr[0] !== 16'h0010 || (c == 1 && mwd[0] !== 16'hBEEF)) begin
          n_bad++;
          $display("FAIL wr_rd_mem T+%0d: addr=%h wdata=%h want 0010/BEEF", c, maddr[0], mwd[0]);
        end
      end
      if (c >= 4) begin
        n_cmp++;
        if (rd[0][0] !== 16'hBEEF || rd[0][1] !== 16'h0000) begin
          n_bad++;
          $display("FAIL wr_rd_data T+%0d: rdata0=%h rdata1=%h want BEEF/0000", c, rd[0][0], rd[0][1]);
        end
      end
      tick();
      if (c == 0) drive(0, 0, 1'b0, 16'h0010, 16'hBEEF);
      if (c == 2) idle_all();
    end
  endtask

  task automatic test_fairness();
    logic [6:0] e;
    int m;
    rst = 1'b1;
    idle_all();
    drive(2, 0, 1'b0, 16'h0001, 16'h0000);
    drive(2, 1, 1'b0, 16'h0002, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m = i % 8;
      e = {m == 0, m == 4, 1'b0, (i % 4) == 1, m == 4, m == 0 && i > 0, (i % 4) != 0};
      n_cmp++;
      if (ctl(2) !== e) begin
        n_bad++;
        $display("FAIL fair_ctl cyc%0d: got %b want %b", i, ctl(2), e);
      end
      if (m == 4 || (m == 0 && i > 0)) begin
        n_cmp++;
        if ((m == 4 && rd[2][0] !== mem_init(1)) || (m == 0 && rd[2][1] !== mem_init(2))) begin
          n_bad++;
          $display("FAIL fair_data cyc%0d: rdata0=%h rdata1=%h want %h/%h",
                   i, rd[2][0], rd[2][1], mem_init(1), mem_init(2));
        end
      end
      tick();
    end
    idle_all();
    repeat (4) tick();
  endtask

  task automatic test_wait_pending();
    logic [6:0] exp_c [7];
    exp_c = '{7'b1000000, 7'b0001001, 7'b0000001, 7'b0000001, 7'b0100100, 7'b0010001, 7'b0000000};
    do_reset();
    drive(2, 0, 1'b0, 16'h0005, 16'h0000);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl(2) !== exp_c[c]) begin
        n_bad++;
        $display("FAIL pend_ctl T+%0d: got %b want %b", c, ctl(2), exp_c[c]);
      end
      if (c == 4) begin
        n_cmp++;
        if (rd[2][0] !== mem_init(5)) begin
          n_bad++;
          $display("FAIL pend_rdata0: got %h want %h", rd[2][0], mem_init(5));
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (maddr[2] !== 16'h0007 || mwd[2] !== 16'h1234) begin
          n_bad++;
          $display("FAIL pend_write: addr=%h wdata=%h want 0007/1234", maddr[2], mwd[2]);
        end
      end
      tick();
      if (c == 0) begin
        idle_all();
        drive(2, 1, 1'b1, 16'h0007, 16'h1234);
      end
      if (c == 4) idle_all();
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 1; p >= 0; p--) begin
      do_reset();
      drive(3, p, 1'b0, 16'h0009, 16'h0000);
      @(negedge clk);
      n_cmp++;
      if (ctl(3) !== (p == 0 ? 7'b1000000 : 7'b0100000)) begin
        n_bad++;
        $display("FAIL rmid_accept port%0d: got %b", p, ctl(3));
      end
      tick();
      idle_all();
      @(negedge clk);
      n_cmp++;
      if (ctl(3) !== 7'b0001001) begin
        n_bad++;
        $display("FAIL rmid_issue port%0d: got %b want 0001001", p, ctl(3));
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({ctl(3), rd[3][0], rd[3][1]} !== 39'd0) begin
          n_bad++;
          $display("FAIL rmid_after port%0d cyc%0d: ctl=%b rd0=%h rd1=%h want 0",
                   p, c, ctl(3), rd[3][0], rd[3][1]);
        end
        tick();
      end
      drive(3, 0, 1'b0, 16'h0001, 16'h0000);
      drive(3, 1, 1'b0, 16'h0002, 16'h0000);
      @(negedge clk);
      n_cmp++;
      if (ctl(3) !== 7'b1000000) begin
        n_bad++;
        $display("FAIL rmid_rrptr port%0d: got %b want 1000000", p, ctl(3));
      end
      tick();
      idle_all();
      repeat (6) tick();
    end
  endtask

  task automatic test_drop();
    logic [6:0] exp_c [8];
    exp_c = '{7'b0100000, 7'b0001001, 7'b0000001, 7'b0000010,
              7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    do_reset();
    drive(1, 1, 1'b0, 16'h0003, 16'h0000);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl(1) !== exp_c[c]) begin
        n_bad++;
        $display("FAIL drop_ctl T+%0d: got %b want %b", c, ctl(1), exp_c[c]);
      end
      if (c == 3) begin
        n_cmp++;
        if (rd[1][1] !== mem_init(3) || rd[1][0] !== 16'h0000) begin
          n_bad++;
          $display("FAIL drop_data: rdata1=%h rdata0=%h want %h/0000", rd[1][1], rd[1][0], mem_init(3));
        end
      end
      tick();
      idle_all();
      if (c == 0) drive(1, 0, 1'b0, 16'h0004, 16'h0000);
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    logic       keep;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          e = {exp_rdy(k, 0), exp_rdy(k, 1),
               mcyc == s_cyc[k] && s_we[k], mcyc == s_cyc[k] && !s_we[k],
               mcyc == rv_cyc[k] && !rv_port[k], mcyc == rv_cyc[k] && rv_port[k],
               mcyc < free_at[k]};
          n_cmp++;
          if (ctl(k) !== e) begin
            n_bad++;
            $display("FAIL rand_ctl dut%0d cyc%0d: got %b want %b", k, mcyc, ctl(k), e);
          end
          n_cmp++;
          if ({rd[k][0], rd[k][1], maddr[k], mwd[k]} !== {held[k][0], held[k][1], e_maddr[k], e_mwd[k]}) begin
            n_bad++;
            $display("FAIL rand_data dut%0d cyc%0d: rd0=%h rd1=%h addr=%h wd=%h want %h %h %h %h",
                     k, mcyc, rd[k][0], rd[k][1], maddr[k], mwd[k],
                     held[k][0], held[k][1], e_maddr[k], e_mwd[k]);
          end
        end
      end
      // Next-cycle stimulus, decided from what the requester sees now.
      keep = 1'b0;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          keep = vv[k][p] && !rdy[k][p];
          if (keep) begin
            if ($urandom_range(0, 15) == 0) vv[k][p] = 1'b0;
          end else begin
            vv[k][p]  = ($urandom_range(0, 3) != 0);
            vwe[k][p] = $urandom_range(0, 1) == 1;
            va[k][p]  = {8'($urandom), 4'h0, 4'($urandom)};
            vd[k][p]  = 16'($urandom);
          end
        end
      tick();
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    idle_all();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    mcyc = 0;
    test_reset();
    test_write_read();
    test_fairness();
    test_wait_pending();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: req0 = CPU load/store port, req1 = loader/DMA port (program and data preload, debug readback).
- Sits between the requesters and the data memory. It drives the memory's address, write-data, write-enable and read-enable, and returns read data to the requester that owns the transaction.
- One transaction in flight at a time. Round-robin grant. The CPU uses req0_ready low as its stall.

Parameters:
- ADDR_W, 16, address width on both requester ports and the memory port.
- DATA_W, 16, data width.
- RD_LAT, 0, memory read latency in cycles after the mem_re cycle; legal range 0..3.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  request present (N = 0, 1 for this and every reqN_* line below)
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- reqN_ready  out  1  request accepted this cycle when valid && ready
- reqN_rvalid  out  1  one-cycle pulse, read data valid
- reqN_rdata  out  DATA_W  read data, held until the next rvalid to the same port
- mem_addr  out  ADDR_W  registered address to memory
- mem_wdata  out  DATA_W  registered write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_re
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (req0 has priority), lat_cnt=0. All mem_*, reqN_ready, reqN_rvalid, reqN_rdata and busy are 0.
- The reset requirement applies on any cycle, including mid-transaction: an in-flight read produces no rvalid, and the strobe is 0 in the cycle after rst.
- States:
  - IDLE: reqN_ready is combinational and is 1 only for the winner.
    - Winner = the sole valid requester, or rr_ptr's port if both are valid.
    - On accept at cycle T: capture addr/wdata/we/owner, set rr_ptr to the other port, go to ISSUE.
    - With no valid requester, remain in IDLE.
  - ISSUE (cycle T+1): exactly one of mem_we or mem_re is 1, and mem_addr/mem_wdata hold the captured values.
    - Write: next state is IDLE.
    - Read with RD_LAT=0: capture mem_rdata this cycle, next state IDLE.
    - Read with RD_LAT>0: load lat_cnt=RD_LAT, go to WAIT.
  - WAIT: decrement lat_cnt. When lat_cnt reaches 1, capture mem_rdata in that cycle and go to IDLE.
- Read response: reqN_rvalid pulses for one cycle, in the cycle after capture, on the owner port only. Read response cycle = T+2+RD_LAT. The arbiter is already in IDLE then and may accept a new request in that same cycle.
- Write throughput: accept every 2 cycles. Read throughput: accept every 2+RD_LAT cycles.
- Outside IDLE: both ready outputs are 0. mem_we and mem_re are never both 1.
- Fairness: when both requesters hold valid continuously, grants strictly alternate, so no requester waits more than one other transaction.
- Requester rules:
  - addr/wdata/we must stay stable while valid && !ready.
  - Dropping valid before acceptance is legal and has no effect.
  - Arbiter captures at accept; later input changes are ignored.
- A valid request arriving during ISSUE or WAIT is accepted at the first IDLE cycle.
- mem_addr and mem_wdata keep their last values when idle; only the strobes return to 0.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - requester IDs REQ_CPU=1'b0, REQ_DMA=1'b1
  - RD_LAT maximum constant (3), lat_cnt width (2)
- Sub-module rr_arb2: combinational two-way round-robin picker. Inputs: valid0, valid1, rr_ptr. Outputs: gnt0, gnt1 (one-hot or zero). The FSM and rr_ptr register stay in dmem_arbiter.

Test Plan:
- Reset then idle, no valids, 5 cycles → all outputs 0, busy=0, no strobes.
- req0 write addr=0x0010 wdata=0xBEEF at T, then req0 read 0x0010 (RD_LAT=0) → ready0=1 at T; mem_we=1 at T+1 with addr 0x0010, wdata 0xBEEF; read accepted T+2; mem_re at T+3; rvalid0=1 with rdata0=0xBEEF at T+4; rvalid1 never asserts.
- Both valid from reset, req0 reads 0x0001 and req1 reads 0x0002, RD_LAT=2 → grant order req0, req1, req0, req1. Accepts 4 cycles apart; each rvalid lands 4 cycles after its accept with the correct data on the correct port.
- req1 write of 0x1234 pending while req0 read is in WAIT → ready1 stays 0 until IDLE. req1 is accepted in the same cycle rvalid0 pulses. mem_we and mem_re are never simultaneously 1.
- rst asserted during WAIT of req1 read (RD_LAT=3) → next cycle state IDLE, no rvalid1, rr_ptr=0. Simultaneous requests afterwards grant req0 first.
- req0 raises valid for 1 cycle while busy, then drops → no transaction issued, no strobe, no rvalid.
